// File: rtl/frame_tick_pkg.sv
// Shared state encoding and default parameters for the frame tick generator.
// Optional FRAME_TICK_CNT_EN adds per-lane tick counters in tick_lane/frame_tick_gen.
package frame_tick_pkg;

  localparam int DEF_NUM_CH  = 4;
  localparam int DEF_SPEED_W = 8;
  localparam int DEF_ACC_W   = 10;
  localparam int DEF_PERIOD  = 240;
  localparam int DEF_PRELOAD = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

endpackage

// File: rtl/tick_lane.sv
// One tick lane: phase accumulator, threshold compare and residual clamp.
// FRAME_TICK_CNT_EN adds a 16-bit wrapping tick counter output.
module tick_lane
  import frame_tick_pkg::*;
#(
  parameter int SPEED_W = DEF_SPEED_W,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int PERIOD  = DEF_PERIOD,
  parameter int PRELOAD = DEF_PRELOAD
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               clear,
  input  logic               update,
  input  logic [SPEED_W-1:0] speed,
  output logic               tick
`ifdef FRAME_TICK_CNT_EN
  ,
  output logic [15:0]        tick_cnt
`endif
);

  localparam logic [ACC_W:0]   PERIOD_X  = (ACC_W+1)'(PERIOD);
  localparam logic [ACC_W:0]   LIMIT_X   = (ACC_W+1)'(PERIOD - 1);
  localparam logic [ACC_W-1:0] PRELOAD_V = ACC_W'(PRELOAD);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W:0]   sum;
  logic [ACC_W:0]   resid;
  logic             hit;
  logic [ACC_W-1:0] acc_next;

  // Residual is clamped so a speed at or above PERIOD still yields one tick per frame.
  always_comb begin
    sum      = {1'b0, acc_q} + {{(ACC_W+1-SPEED_W){1'b0}}, speed};
    hit      = (sum >= PERIOD_X);
    resid    = sum - PERIOD_X;
    if (resid > LIMIT_X) resid = LIMIT_X;
    acc_next = hit ? resid[ACC_W-1:0] : sum[ACC_W-1:0];
  end

  always_ff @(posedge CLK) begin
    if (reset || clear) begin
      acc_q <= PRELOAD_V;
      tick  <= 1'b0;
    end else begin
      tick <= update && hit;
      if (update) acc_q <= acc_next;
    end
  end

`ifdef FRAME_TICK_CNT_EN
  always_ff @(posedge CLK) begin
    if (reset || clear)    tick_cnt <= 16'd0;
    else if (update && hit) tick_cnt <= tick_cnt + 16'd1;
  end
`endif

endmodule

// File: rtl/frame_tick_gen.sv
// Frame-synchronous tick generator: one frame pulse per VGA origin, RUN/PAUSED/IDLE FSM,
// NUM_CH accumulator lanes. FRAME_TICK_CNT_EN exposes per-lane tick counters on tick_cnt.
module frame_tick_gen
  import frame_tick_pkg::*;
#(
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int SPEED_W = DEF_SPEED_W,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int PERIOD  = DEF_PERIOD,
  parameter int PRELOAD = DEF_PRELOAD
) (
  input  logic                        CLK,
  input  logic                        reset,
  input  logic [9:0]                  hc,
  input  logic [9:0]                  vc,
  input  logic                        run_en,
  input  logic                        pause,
  input  logic [NUM_CH-1:0]           ch_en,
  input  logic [NUM_CH*SPEED_W-1:0]   speed,
  output logic [NUM_CH-1:0]           tick,
  output logic                        frame_strobe,
  output logic [1:0]                  state
`ifdef FRAME_TICK_CNT_EN
  ,
  output logic [NUM_CH*16-1:0]        tick_cnt
`endif
);

  state_t state_q, state_d;
  logic   origin, origin_q, frame_pulse;

  assign origin      = (hc == 10'd0) && (vc == 10'd0);
  assign frame_pulse = origin && !origin_q;
  assign state       = state_q;

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q      <= IDLE;
      origin_q     <= 1'b0;
      frame_strobe <= 1'b0;
    end else begin
      state_q      <= state_d;
      origin_q     <= origin;
      frame_strobe <= frame_pulse;
    end
  end

  // Dropping run_en wins over any frame-pulse transition.
  always_comb begin
    state_d = state_q;
    if (!run_en) begin
      state_d = IDLE;
    end else if (frame_pulse) begin
      case (state_q)
        IDLE:    state_d = pause ? PAUSED : RUN;
        RUN:     if (pause) state_d = PAUSED;
        PAUSED:  if (!pause) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // Lanes see the pre-transition state, so the frame that enters PAUSED still updates.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    tick_lane #(
      .SPEED_W (SPEED_W),
      .ACC_W   (ACC_W),
      .PERIOD  (PERIOD),
      .PRELOAD (PRELOAD)
    ) u_lane (
      .CLK      (CLK),
      .reset    (reset),
      .clear    (!run_en),
      .update   (frame_pulse && (state_q == RUN) && ch_en[i]),
      .speed    (speed[i*SPEED_W +: SPEED_W]),
      .tick     (tick[i])
`ifdef FRAME_TICK_CNT_EN
      ,
      .tick_cnt (tick_cnt[i*16 +: 16])
`endif
    );
  end

endmodule

// File: tb/tb_frame_tick_gen.sv
// Bench for frame_tick_gen: table of per-frame vectors plus hand sequences for
// held origin, run_en drop, IDLE strobe and reset; expectations flow through exp_q.
module tb_frame_tick_gen;
  import frame_tick_pkg::*;

  localparam int W = 47;  // {tick[3:0], strobe, state[1:0], acc[39:0]}

  logic        CLK = 1'b0;
  logic        reset;
  logic [9:0]  hc, vc;
  logic        run_en, pause;
  logic [3:0]  ch_en;
  logic [31:0] speed;
  logic [3:0]  tick;
  logic        frame_strobe;
  logic [1:0]  state;
`ifdef FRAME_TICK_CNT_EN
  logic [63:0] tick_cnt;
`endif
  logic [39:0] acc_mon;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_err    = 0;

  typedef struct packed {
    logic        run_en;
    logic        pause;
    logic [3:0]  ch_en;
    logic [31:0] speed;
    logic [3:0]  tick;
    logic [1:0]  st;
    logic [39:0] acc;
  } vec_t;

  // clock / reset block
  always #5 CLK = ~CLK;

  frame_tick_gen dut (
    .CLK          (CLK),
    .reset        (reset),
    .hc           (hc),
    .vc           (vc),
    .run_en       (run_en),
    .pause        (pause),
    .ch_en        (ch_en),
    .speed        (speed),
    .tick         (tick),
    .frame_strobe (frame_strobe),
    .state        (state)
`ifdef FRAME_TICK_CNT_EN
    ,
    .tick_cnt     (tick_cnt)
`endif
  );

  assign acc_mon = {dut.g_lane[3].u_lane.acc_q, dut.g_lane[2].u_lane.acc_q,
                    dut.g_lane[1].u_lane.acc_q, dut.g_lane[0].u_lane.acc_q};

  function automatic logic [31:0] sp(input int s0, input int s1, input int s2, input int s3);
    return {8'(s3), 8'(s2), 8'(s1), 8'(s0)};
  endfunction

  function automatic logic [39:0] ac(input int a0, input int a1, input int a2, input int a3);
    return {10'(a3), 10'(a2), 10'(a1), 10'(a0)};
  endfunction

  function automatic vec_t mk(input logic r, input logic p, input logic [3:0] ce,
                              input logic [31:0] s, input logic [3:0] t,
                              input logic [1:0] st, input logic [39:0] a);
    vec_t v;
    v.run_en = r; v.pause = p; v.ch_en = ce; v.speed = s;
    v.tick = t; v.st = st; v.acc = a;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver: one CLK cycle with origin on/off; expectation for the following cycle is queued
  task automatic cyc(input string tag, input logic org, input logic [3:0] etick,
                     input logic estb, input logic [1:0] est, input logic [39:0] eacc);
    logic [W-1:0] e;
    hc = org ? 10'd0 : 10'd17;
    vc = org ? 10'd0 : 10'd9;
    exp_q.push_back({etick, estb, est, eacc});
    @(posedge CLK);
    #1;
    e = exp_q.pop_front();
    check({tag, " tick"},   64'(tick),         64'(e[46:43]));
    check({tag, " strobe"}, 64'(frame_strobe), 64'(e[42]));
    check({tag, " state"},  64'(state),        64'(e[41:40]));
    check({tag, " acc"},    64'(acc_mon),      64'(e[39:0]));
    check({tag, " acc1 bound"}, 64'(acc_mon[19:10] <= 10'd239), 64'd1);
  endtask

  vec_t vecs[15];

  initial begin
    logic [31:0] s_a, s_b, s_c, s_d;
    s_a = sp(60, 255, 120, 0);
    s_b = sp(120, 120, 120, 120);
    s_c = sp(0, 0, 0, 239);
    s_d = sp(0, 0, 0, 255);
    vecs[0]  = mk(1, 0, 4'b1111, s_a, 4'b0000, RUN,    ac(0, 0, 0, 0));
    vecs[1]  = mk(1, 0, 4'b1111, s_a, 4'b0010, RUN,    ac(60, 15, 120, 0));
    vecs[2]  = mk(1, 0, 4'b1111, s_a, 4'b0110, RUN,    ac(120, 30, 0, 0));
    vecs[3]  = mk(1, 0, 4'b1111, s_a, 4'b0010, RUN,    ac(180, 45, 120, 0));
    vecs[4]  = mk(1, 0, 4'b1111, s_a, 4'b0111, RUN,    ac(0, 60, 0, 0));
    vecs[5]  = mk(1, 1, 4'b1111, s_a, 4'b0010, PAUSED, ac(60, 75, 120, 0));
    vecs[6]  = mk(1, 1, 4'b1111, s_a, 4'b0000, PAUSED, ac(60, 75, 120, 0));
    vecs[7]  = mk(1, 0, 4'b1111, s_a, 4'b0000, RUN,    ac(60, 75, 120, 0));
    vecs[8]  = mk(1, 0, 4'b1111, s_a, 4'b0110, RUN,    ac(120, 90, 0, 0));
    vecs[9]  = mk(1, 0, 4'b0101, s_b, 4'b0001, RUN,    ac(0, 90, 120, 0));
    vecs[10] = mk(1, 0, 4'b0101, s_b, 4'b0100, RUN,    ac(120, 90, 0, 0));
    vecs[11] = mk(1, 0, 4'b0101, s_b, 4'b0001, RUN,    ac(0, 90, 120, 0));
    vecs[12] = mk(1, 0, 4'b1000, s_c, 4'b0000, RUN,    ac(0, 90, 120, 239));
    vecs[13] = mk(1, 0, 4'b1000, s_d, 4'b1000, RUN,    ac(0, 90, 120, 239));
    vecs[14] = mk(1, 0, 4'b1000, s_d, 4'b1000, RUN,    ac(0, 90, 120, 239));

    // reset held over an origin with run_en high: nothing may leak through
    reset = 1'b1; run_en = 1'b1; pause = 1'b0; ch_en = 4'b1111; speed = s_a;
    cyc("reset0", 1, 4'b0000, 1'b0, IDLE, ac(0, 0, 0, 0));
    cyc("reset1", 1, 4'b0000, 1'b0, IDLE, ac(0, 0, 0, 0));
    reset = 1'b0;
    cyc("post_reset", 0, 4'b0000, 1'b0, IDLE, ac(0, 0, 0, 0));

    for (int i = 0; i < 15; i++) begin
      run_en = vecs[i].run_en;
      pause  = vecs[i].pause;
      ch_en  = vecs[i].ch_en;
      speed  = vecs[i].speed;
      cyc($sformatf("vec%0d", i), 1, vecs[i].tick, 1'b1, vecs[i].st, vecs[i].acc);
      for (int g = 0; g < 2; g++)
        cyc($sformatf("vec%0d gap", i), 0, 4'b0000, 1'b0, vecs[i].st, vecs[i].acc);
    end

    // origin held for 5 cycles: one strobe, one tick
    ch_en = 4'b0001; speed = sp(255, 0, 0, 0);
    cyc("hold0", 1, 4'b0001, 1'b1, RUN, ac(15, 90, 120, 239));
    for (int k = 1; k < 5; k++)
      cyc($sformatf("hold%0d", k), 1, 4'b0000, 1'b0, RUN, ac(15, 90, 120, 239));
    cyc("hold end", 0, 4'b0000, 1'b0, RUN, ac(15, 90, 120, 239));

    // run_en dropped mid-frame
    run_en = 1'b0;
    cyc("drop", 0, 4'b0000, 1'b0, IDLE, ac(0, 0, 0, 0));
`ifdef FRAME_TICK_CNT_EN
    check("drop tick_cnt", tick_cnt, 64'd0);
`endif

    // strobe still pulses in IDLE; IDLE->PAUSED->RUN, then counting starts
    cyc("idle frame", 1, 4'b0000, 1'b1, IDLE, ac(0, 0, 0, 0));
    cyc("idle gap", 0, 4'b0000, 1'b0, IDLE, ac(0, 0, 0, 0));
    run_en = 1'b1; pause = 1'b1;
    cyc("idle->paused", 1, 4'b0000, 1'b1, PAUSED, ac(0, 0, 0, 0));
    cyc("paused gap", 0, 4'b0000, 1'b0, PAUSED, ac(0, 0, 0, 0));
    pause = 1'b0;
    cyc("paused->run", 1, 4'b0000, 1'b1, RUN, ac(0, 0, 0, 0));
    cyc("run gap", 0, 4'b0000, 1'b0, RUN, ac(0, 0, 0, 0));
    cyc("run tick", 1, 4'b0001, 1'b1, RUN, ac(15, 0, 0, 0));
    cyc("run tick gap", 0, 4'b0000, 1'b0, RUN, ac(15, 0, 0, 0));

    // reset in RUN on an origin cycle overrides the frame
    reset = 1'b1;
    cyc("reset in run", 1, 4'b0000, 1'b0, IDLE, ac(0, 0, 0, 0));
`ifdef FRAME_TICK_CNT_EN
    check("reset tick_cnt", tick_cnt, 64'd0);
`endif
    reset = 1'b0;
    cyc("after reset", 0, 4'b0000, 1'b0, IDLE, ac(0, 0, 0, 0));

    // final report
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/frame_tick_gen.md
FRAME_TICK_GEN -- requirements
Module: frame_tick_gen

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent tick lanes (one per arrow column).
REQ-002 Parameter SPEED_W, default 8: width of each lane's per-frame speed increment.
REQ-003 Parameter ACC_W, default 10: phase accumulator width; must satisfy 2^ACC_W > PERIOD-1 + 2^SPEED_W-1.
REQ-004 Parameter PERIOD, default 240: accumulator threshold for one tick.
REQ-005 Parameter PRELOAD, default 0: accumulator value loaded on reset and on entry to IDLE.
REQ-006 CLK  input  1  system clock; all logic on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 hc  input  10  horizontal pixel counter from VGA timing.
REQ-009 vc  input  10  vertical line counter from VGA timing.
REQ-010 run_en  input  1  game running; low forces IDLE.
REQ-011 pause  input  1  freeze all lanes, sampled at frame pulse.
REQ-012 ch_en  input  NUM_CH  per-lane enable.
REQ-013 speed  input  NUM_CH*SPEED_W  packed per-lane increments, lane i at [i*SPEED_W +: SPEED_W].
REQ-014 tick  output  NUM_CH  per-lane one-CLK tick pulse.
REQ-015 frame_strobe  output  1  one-CLK pulse per frame origin.
REQ-016 state  output  2  FSM state: IDLE=0, RUN=1, PAUSED=2.

Function
REQ-017 origin = (hc==0 && vc==0); frame pulse = origin && !origin_q, origin_q registered; exactly one pulse per frame regardless of how many CLK cycles origin persists.
REQ-018 frame_strobe and tick are registered: frame pulse in cycle N produces outputs high in cycle N+1 only.
REQ-019 FSM IDLE -> RUN on frame pulse with run_en=1 and pause=0; IDLE -> PAUSED on frame pulse with run_en=1 and pause=1.
REQ-020 RUN -> PAUSED on frame pulse with pause=1; PAUSED -> RUN on frame pulse with pause=0.
REQ-021 Any state -> IDLE on the next CLK edge when run_en=0, regardless of frame pulse; all accumulators load PRELOAD.
REQ-022 Lane update only on frame pulse while state is RUN and ch_en[i]=1; otherwise accumulator held, tick[i]=0.
REQ-023 Lane update: sum = acc + speed[i] at ACC_W+1 bits; if sum >= PERIOD then tick[i]=1, acc = min(sum-PERIOD, PERIOD-1), else acc = sum.
REQ-024 At most one tick per lane per frame; residual clamp (REQ-023) applies when speed >= PERIOD.
REQ-025 speed[i]=0 never ticks; acc held.
REQ-026 A frame pulse in the same cycle as an FSM transition updates lanes using the pre-transition state.
REQ-027 frame_strobe pulses every frame in all states, including IDLE.

Reset
REQ-028 reset=1 at a CLK edge: state=IDLE, all accumulators=PRELOAD, origin_q=0, tick=0, frame_strobe=0, tick counters=0; reset overrides all other inputs, including mid-frame.

Configuration
REQ-029 Macro FRAME_TICK_CNT_EN defined: add output tick_cnt (NUM_CH*16), a per-lane 16-bit wrapping count of ticks, cleared by reset and on entry to IDLE.
REQ-030 FRAME_TICK_CNT_EN undefined: no tick_cnt port and no counter logic; all other behaviour identical.

Structure
REQ-031 Package frame_tick_pkg holds the state encoding (IDLE, RUN, PAUSED) and default parameter constants.
REQ-032 Sub-module tick_lane implements one accumulator, comparator, clamp and optional counter; it is instantiated NUM_CH times by generate.

Verification
REQ-033 Defaults, lane0 speed=60, RUN -> tick[0] on every 4th frame pulse; acc returns to 0.
REQ-034 Lane1 speed=255 -> tick every frame; acc sequence 15, 30, ...; acc never exceeds 239.
REQ-035 hc=vc=0 held 5 CLK cycles -> single frame_strobe and at most one tick per lane.
REQ-036 pause=1 at frame k -> no ticks and acc frozen until the first frame pulse with pause=0, then counting resumes from the held acc.
REQ-037 run_en dropped mid-frame -> state=IDLE next cycle, acc=PRELOAD, tick_cnt=0 (macro on); reset asserted in RUN gives the same outcome.
REQ-038 ch_en=4'b0101, all speeds 120 -> lanes 0 and 2 tick every 2nd frame; lanes 1 and 3 never tick.
